soh_sel_decoder: RTL and testbench

Decode-stage block that turns a fetched 32-bit SPARC-style instruction into the operand-select control word and immediate fields consumed by the second operand handler. It sits between fetch and execute. It accepts instructions over a valid/ready handshake, decodes the fields, and presents them from a registered output stage. A one-entry skid buffer keeps back-pressure off the combinational path.

---
 rtl/soh_sel_decoder.sv | 172 +++++++++++++++++
 tb/tb_soh_sel_decoder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/soh_sel_decoder.sv
// Operand-select decoder for the second operand handler, with a skid-buffered output stage.
// Define SOH_DEC_ILLEGAL_EN to build illegal-encoding detection into out_illegal.
module soh_sel_decoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_inst,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_sel,
    output logic [12:0] out_imm13,
    output logic [21:0] out_imm22,
    output logic [4:0]  out_rs2,
    output logic        out_illegal
);

    typedef struct packed {
        logic [3:0]  sel;
        logic [12:0] imm13;
        logic [21:0] imm22;
        logic [4:0]  rs2;
    } fld_t;

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [1:0] op;
    logic [2:0] op2;
    logic [5:0] op3;
    logic       ibit;
    logic       shift_op;
    logic       bad;
    logic [3:0] base_sel;
    logic [4:0] unused_rd;
    fld_t       dec;
    fld_t       out_q;
    fld_t       skid_q;
    logic       accept;
    logic       drain;
    logic       load_in;
    logic       load_skid;
    logic       skid_to_out;

    assign op        = in_inst[31:30];
    assign op2       = in_inst[24:22];
    assign op3       = in_inst[24:19];
    assign ibit      = in_inst[13];
    assign unused_rd = in_inst[29:25];
    assign shift_op  = (op3 == 6'b100101) || (op3 == 6'b100110) ||
                       (op3 == 6'b100111);

`ifdef SOH_DEC_ILLEGAL_EN
    assign bad = ((op == 2'b00) && (op2 != 3'b010) && (op2 != 3'b100)) ||
                 ((op == 2'b10) && ((op3 == 6'b001001) ||
                                    (op3 == 6'b001101) ||
                                    (op3 == 6'b101101))) ||
                 ((op == 2'b11) && op3[5]);
`else
    assign bad = 1'b0;
`endif

    always_comb begin
        base_sel = 4'b0000;
        unique case (op)
            2'b00: begin
                if (op2 == 3'b100)
                    base_sel = 4'b0010;
                else if (op2 == 3'b010)
                    base_sel = 4'b0011;
            end
            2'b01: base_sel = 4'b0000;
            2'b10: base_sel = {1'b0, shift_op, 1'b0, ibit};
            2'b11: base_sel = {3'b000, ibit};
            default: base_sel = 4'b0000;
        endcase
    end

    assign dec.sel   = bad ? 4'b0000 : base_sel;
    assign dec.imm13 = in_inst[12:0];
    assign dec.imm22 = in_inst[21:0];
    assign dec.rs2   = in_inst[4:0];

    // Ready depends only on occupancy, keeping out_ready off the input path.
    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;

    always_comb begin
        state_nxt   = state;
        load_in     = 1'b0;
        load_skid   = 1'b0;
        skid_to_out = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    load_in   = 1'b1;
                    state_nxt = ONE;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    load_in = 1'b1;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_nxt = TWO;
                end else if (drain) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (drain) begin
                    skid_to_out = 1'b1;
                    state_nxt   = ONE;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= EMPTY;
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            state <= flush ? EMPTY : state_nxt;
            if (!flush) begin
                if (load_in)
                    out_q <= dec;
                else if (skid_to_out)
                    out_q <= skid_q;
                if (load_skid)
                    skid_q <= dec;
            end
        end
    end

`ifdef SOH_DEC_ILLEGAL_EN
    logic out_ill_q;
    logic skid_ill_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_ill_q  <= 1'b0;
            skid_ill_q <= 1'b0;
        end else if (!flush) begin
            if (load_in)
                out_ill_q <= bad;
            else if (skid_to_out)
                out_ill_q <= skid_ill_q;
            if (load_skid)
                skid_ill_q <= bad;
        end
    end

    assign out_illegal = out_ill_q;
`else
    assign out_illegal = 1'b0;
`endif

    assign out_sel   = out_q.sel;
    assign out_imm13 = out_q.imm13;
    assign out_imm22 = out_q.imm22;
    assign out_rs2   = out_q.rs2;

endmodule

// File: tb/tb_soh_sel_decoder.sv
// Bench for soh_sel_decoder: decode table, handshake corner cases, random vs model.
// Honours SOH_DEC_ILLEGAL_EN the same way as the design.
module tb_soh_sel_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_sel;
    logic [12:0] out_imm13;
    logic [21:0] out_imm22;
    logic [4:0]  out_rs2;
    logic        out_illegal;

    int vectors = 0;
    int errs    = 0;

`ifdef SOH_DEC_ILLEGAL_EN
    localparam bit ILL = 1'b1;
`else
    localparam bit ILL = 1'b0;
`endif

    typedef struct {
        logic [31:0] inst;
        logic [3:0]  sel;
        logic        ill;
    } vec_t;

    typedef struct packed {
        logic [3:0]  sel;
        logic [12:0] imm13;
        logic [21:0] imm22;
        logic [4:0]  rs2;
        logic        ill;
    } rec_t;

    soh_sel_decoder dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sel(out_sel), .out_imm13(out_imm13), .out_imm22(out_imm22),
        .out_rs2(out_rs2), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Straight from the instruction-set rules, not from any encoding of the RTL.
    function automatic rec_t ref_dec(input logic [31:0] w);
        rec_t r;
        int op, op2, op3;
        bit i, ill;
        int s;
        op  = int'(w[31:30]);
        op2 = int'(w[24:22]);
        op3 = int'(w[24:19]);
        i   = w[13];
        ill = 0;
        s   = 0;
        if (op == 0) begin
            if (op2 == 4) s = 2;
            else if (op2 == 2) s = 3;
            else ill = 1;
        end else if (op == 1) begin
            s = 0;
        end else if (op == 2) begin
            if (op3 == 'h25 || op3 == 'h26 || op3 == 'h27) s = i ? 5 : 4;
            else s = i ? 1 : 0;
            ill = (op3 == 'h09 || op3 == 'h0d || op3 == 'h2d);
        end else begin
            s = i ? 1 : 0;
            ill = (op3 >= 32);
        end
        if (!ILL) ill = 0;
        if (ill) s = 0;
        r.sel   = 4'(s);
        r.imm13 = w[12:0];
        r.imm22 = w[21:0];
        r.rs2   = w[4:0];
        r.ill   = ill;
        return r;
    endfunction

    function automatic logic [31:0] sethi(input logic [21:0] imm);
        return {2'b00, 5'd1, 3'b100, imm};
    endfunction

    vec_t tbl[12];
    rec_t q[$];
    logic [21:0] got[$];
    logic [5:0] hot[6];

    initial begin
        tbl[0]  = '{32'h80A06005, 4'h1, 1'b0};
        tbl[1]  = '{32'h03000010, 4'h2, 1'b0};
        tbl[2]  = '{32'h10800004, 4'h3, 1'b0};
        tbl[3]  = '{32'h912A0009, 4'h4, 1'b0};
        tbl[4]  = '{32'h912A2003, 4'h5, 1'b0};
        tbl[5]  = '{32'h01C00000, 4'h0, ILL};
        tbl[6]  = '{32'h40000010, 4'h0, 1'b0};
        tbl[7]  = '{32'hC2006004, 4'h1, 1'b0};
        tbl[8]  = '{32'hC1002000, ILL ? 4'h0 : 4'h1, ILL};
        tbl[9]  = '{32'h80482000, ILL ? 4'h0 : 4'h1, ILL};
        tbl[10] = '{32'h81300003, 4'h4, 1'b0};
        tbl[11] = '{32'h81382005, 4'h5, 1'b0};
        hot = '{6'h25, 6'h26, 6'h27, 6'h09, 6'h0d, 6'h2d};

        reset = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        in_inst = 32'hFFFF_FFFF;
        out_ready = 1'b0;
        step();
        step();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_fields", {out_sel, out_imm13, out_imm22, out_rs2, out_illegal},
            64'd0);
        reset = 1'b0;

        for (int k = 0; k < 12; k++) begin
            in_valid = 1'b1;
            in_inst = tbl[k].inst;
            out_ready = 1'b1;
            step();
            in_valid = 1'b0;
            chk($sformatf("tbl%0d_valid", k), 64'(out_valid), 64'd1);
            chk($sformatf("tbl%0d_sel", k), 64'(out_sel), 64'(tbl[k].sel));
            chk($sformatf("tbl%0d_ill", k), 64'(out_illegal), 64'(tbl[k].ill));
            chk($sformatf("tbl%0d_flds", k), {out_imm13, out_imm22, out_rs2},
                {tbl[k].inst[12:0], tbl[k].inst[21:0], tbl[k].inst[4:0]});
            step();
            chk($sformatf("tbl%0d_drained", k), 64'(out_valid), 64'd0);
        end

        // Back-pressure: two accepted, third held by source, then FIFO drain.
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_inst = sethi(22'h111);
        step();
        chk("bp_v1", 64'(out_valid), 64'd1);
        chk("bp_r1", 64'(in_ready), 64'd1);
        in_inst = sethi(22'h222);
        step();
        chk("bp_r2", 64'(in_ready), 64'd0);
        in_inst = sethi(22'h333);
        step();
        chk("bp_r3", 64'(in_ready), 64'd0);
        chk("bp_hold", 64'(out_imm22), 64'h111);
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bit acc, dr;
            acc = in_valid && in_ready;
            dr = out_valid && out_ready;
            if (dr) got.push_back(out_imm22);
            step();
            if (acc) in_valid = 1'b0;
            if (got.size() == 3) break;
        end
        chk("bp_count", 64'(got.size()), 64'd3);
        if (got.size() == 3) begin
            chk("bp_ord0", 64'(got[0]), 64'h111);
            chk("bp_ord1", 64'(got[1]), 64'h222);
            chk("bp_ord2", 64'(got[2]), 64'h333);
        end
        step();
        chk("bp_empty", 64'(out_valid), 64'd0);

        // Flush while full, with a simultaneous offer that must be dropped.
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_inst = sethi(22'h0AA);
        step();
        in_inst = sethi(22'h0BB);
        step();
        chk("fl_full", 64'(in_ready), 64'd0);
        flush = 1'b1;
        in_inst = sethi(22'h0CC);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", 64'(out_valid), 64'd0);
        chk("fl_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("fl_ghost%0d", k), 64'(out_valid), 64'd0);
        end

        // Reset while full discards everything.
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_inst = 32'h912A2003;
        step();
        step();
        reset = 1'b1;
        in_valid = 1'b0;
        step();
        chk("mr_valid", 64'(out_valid), 64'd0);
        chk("mr_ready", 64'(in_ready), 64'd1);
        chk("mr_fields", {out_sel, out_imm13, out_imm22, out_rs2, out_illegal},
            64'd0);
        reset = 1'b0;
        step();

        // Random traffic against the queue model.
        for (int c = 0; c < 3000; c++) begin
            bit acc, dr;
            logic [31:0] w;
            chk("rnd_valid", 64'(out_valid), 64'(q.size() > 0));
            chk("rnd_ready", 64'(in_ready), 64'(q.size() < 2));
            if (q.size() > 0)
                chk("rnd_data",
                    {out_sel, out_imm13, out_imm22, out_rs2, out_illegal},
                    64'(q[0]));
            w = $urandom;
            if ($urandom_range(0, 2) == 0) w[24:19] = hot[$urandom_range(0, 5)];
            in_inst = w;
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 31) == 0);
            if (flush) begin
                q.delete();
            end else begin
                acc = in_valid && (q.size() < 2);
                dr = (q.size() > 0) && out_ready;
                if (dr) void'(q.pop_front());
                if (acc) q.push_back(ref_dec(w));
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
